// File: rtl/dram_rr_arbiter_if.sv
// Bundle of per-channel request/response signals and the single DRAM port
// served by dram_rr_arbiter. The requester/DRAM environment uses the master
// modport and the arbiter uses the slave modport.
interface dram_rr_arbiter_if #(
    parameter int CH_NUM = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [CH_NUM-1:0]        req_valid;
    logic [CH_NUM-1:0]        req_ready;
    logic [CH_NUM-1:0]        req_wen;
    logic [CH_NUM*ADDR_W-1:0] req_addr;
    logic [CH_NUM*DATA_W-1:0] req_data;
    logic                     mem_ready;
    logic                     mem_en;
    logic                     mem_wen;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;
    logic [CH_NUM-1:0]        resp_valid;
    logic [CH_NUM*DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_wen, req_addr, req_data, mem_ready, mem_rdata,
        input  req_ready, mem_en, mem_wen, mem_addr, mem_wdata, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_data, mem_ready, mem_rdata,
        output req_ready, mem_en, mem_wen, mem_addr, mem_wdata, resp_valid, resp_data
    );
endinterface

// File: rtl/dram_rr_arbiter.sv
// dram_rr_arbiter: multiplexes CH_NUM DRAM request channels onto one DRAM port.
// One grant per cycle, registered DRAM command outputs, and read data routed
// back to the issuing channel through an RD_LAT-deep tag pipeline.
// Build option: define DRAM_ARB_FIXED_PRIO_EN for fixed priority (channel 0
// highest, no rotating pointer); default build is round-robin.
module dram_rr_arbiter #(
    parameter int CH_NUM = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    dram_rr_arbiter_if.slave   io_bus
);
    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic [CH_NUM-1:0]             w_grant;
    logic [CH_W-1:0]               w_grant_id;
    logic                          w_hs;

    logic                          r_mem_en;
    logic                          r_mem_wen;
    logic [ADDR_W-1:0]             r_mem_addr;
    logic [DATA_W-1:0]             r_mem_wdata;
    logic [CH_W-1:0]               r_issue_ch;

    logic [RD_LAT-1:0]             r_tag_vld;
    logic [RD_LAT-1:0][CH_W-1:0]   r_tag_ch;
    logic [CH_W-1:0]               w_ret_ch;

    logic [CH_NUM-1:0]             r_resp_valid;
    logic [CH_NUM*DATA_W-1:0]      r_resp_data;

`ifdef DRAM_ARB_FIXED_PRIO_EN
    // Fixed-priority pick: scan downward so the lowest valid channel wins last.
    always_comb begin
        w_hs       = 1'b0;
        w_grant_id = '0;
        if (io_bus.mem_ready) begin
            for (int k = CH_NUM - 1; k >= 0; k--) begin
                if (io_bus.req_valid[k]) begin
                    w_hs       = 1'b1;
                    w_grant_id = CH_W'(k);
                end else begin
                    w_grant_id = w_grant_id;
                end
            end
        end else begin
            w_hs = 1'b0;
        end
    end
`else
    logic [CH_W-1:0] r_rr_ptr;

    // Round-robin pick: scan offsets downward from r_rr_ptr so the nearest
    // valid channel (smallest offset, modulo CH_NUM) is the one that sticks.
    always_comb begin
        logic [CH_W:0] v_sum;
        w_hs       = 1'b0;
        w_grant_id = '0;
        v_sum      = '0;
        if (io_bus.mem_ready) begin
            for (int off = CH_NUM - 1; off >= 0; off--) begin
                v_sum = {1'b0, r_rr_ptr} + (CH_W + 1)'(off);
                if (v_sum >= (CH_W + 1)'(CH_NUM)) begin
                    v_sum = v_sum - (CH_W + 1)'(CH_NUM);
                end else begin
                    v_sum = v_sum;
                end
                if (io_bus.req_valid[v_sum[CH_W-1:0]]) begin
                    w_hs       = 1'b1;
                    w_grant_id = v_sum[CH_W-1:0];
                end else begin
                    w_grant_id = w_grant_id;
                end
            end
        end else begin
            w_hs = 1'b0;
        end
    end

    // Rotate the pointer to the channel after the one just served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            if (w_grant_id == CH_W'(CH_NUM - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_grant_id + CH_W'(1);
            end
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`endif

    // Expand the winning channel id into the one-hot ready vector.
    always_comb begin
        w_grant = '0;
        if (w_hs) begin
            w_grant[w_grant_id] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    // Register the DRAM command; address/data hold when nothing is granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_en    <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_issue_ch  <= '0;
        end else if (w_hs) begin
            r_mem_en    <= 1'b1;
            r_mem_wen   <= io_bus.req_wen[w_grant_id];
            r_mem_addr  <= io_bus.req_addr[w_grant_id*ADDR_W +: ADDR_W];
            r_mem_wdata <= io_bus.req_data[w_grant_id*DATA_W +: DATA_W];
            r_issue_ch  <= w_grant_id;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_wen   <= r_mem_wen;
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
            r_issue_ch  <= r_issue_ch;
        end
    end

    // Read tags enter alongside the issued command and shift every edge,
    // independent of mem_ready, so they line up with the DRAM latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_vld <= '0;
            r_tag_ch  <= '0;
        end else begin
            r_tag_vld[0] <= r_mem_en & ~r_mem_wen;
            r_tag_ch[0]  <= r_issue_ch;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_ch[i]  <= r_tag_ch[i-1];
            end
        end
    end

    assign w_ret_ch = r_tag_ch[RD_LAT-1];

    // Capture returning read data into the issuing channel's slot; other
    // slots keep their last value, the strobe lasts one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else if (r_tag_vld[RD_LAT-1]) begin
            r_resp_valid           <= '0;
            r_resp_valid[w_ret_ch] <= 1'b1;
            r_resp_data[w_ret_ch*DATA_W +: DATA_W] <= io_bus.mem_rdata;
        end else begin
            r_resp_valid <= '0;
            r_resp_data  <= r_resp_data;
        end
    end

    assign io_bus.req_ready  = w_grant;
    assign io_bus.mem_en     = r_mem_en;
    assign io_bus.mem_wen    = r_mem_wen;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_wdata  = r_mem_wdata;
    assign io_bus.resp_valid = r_resp_valid;
    assign io_bus.resp_data  = r_resp_data;
endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Testbench for dram_rr_arbiter: DRAM stub plus a queue-based reference model
// of grant order, command outputs and read-return timing.
module tb_dram_rr_arbiter;
    localparam int CH  = 3;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dram_rr_arbiter_if #(.CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dram_rr_arbiter #(.CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus)
    );

    // DRAM stub: write stores, read returns stored data or addr+1, LAT edges later
    logic [DW-1:0]   st_mem [0:65535];
    logic [65535:0]  st_wr = '0;
    logic [DW-1:0]   st_d0 = '0;
    logic [DW-1:0]   st_d1 = '0;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_wen) begin
            st_mem[bus.mem_addr] <= bus.mem_wdata;
            st_wr[bus.mem_addr]  <= 1'b1;
        end
        st_d0 <= st_wr[bus.mem_addr] ? st_mem[bus.mem_addr] : bus.mem_addr + 16'd1;
        st_d1 <= st_d0;
    end
    assign bus.mem_rdata = st_d1;

    // Reference model state
    typedef struct { int due; int ch; logic [DW-1:0] d; } resp_t;
    resp_t           pend[$];
    logic [DW-1:0]   ref_mem [int];
    int              ptr;
    int              cyc;
    logic            e_en, e_wen;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata;
    logic [CH-1:0]   e_rv;
    logic [CH*DW-1:0] e_rd;

    // Requester state (held until granted)
    logic            p_valid [CH];
    logic            p_wen   [CH];
    logic [AW-1:0]   p_addr  [CH];
    logic [DW-1:0]   p_data  [CH];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [CH-1:0] v, input logic rdy);
        if (!rdy) return -1;
`ifdef DRAM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < CH; k++) if (v[k]) return k;
`else
        for (int off = 0; off < CH; off++) if (v[(ptr + off) % CH]) return (ptr + off) % CH;
`endif
        return -1;
    endfunction

    task automatic set_req(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_valid[k] = 1'b1; p_wen[k] = w; p_addr[k] = a; p_data[k] = d;
    endtask

    task automatic apply();
        for (int k = 0; k < CH; k++) begin
            bus.req_valid[k]          = p_valid[k];
            bus.req_wen[k]            = p_wen[k];
            bus.req_addr[k*AW +: AW]  = p_addr[k];
            bus.req_data[k*DW +: DW]  = p_data[k];
        end
    endtask

    task automatic model_reset();
        e_en = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_rv = '0; e_rd = '0;
        ptr = 0;
        pend.delete();
    endtask

    task automatic chk_outputs();
        chk("mem_en",     {63'd0, bus.mem_en},  {63'd0, e_en});
        chk("mem_wen",    {63'd0, bus.mem_wen}, {63'd0, e_wen});
        chk("mem_addr",   64'(bus.mem_addr),    64'(e_addr));
        chk("mem_wdata",  64'(bus.mem_wdata),   64'(e_wdata));
        chk("resp_valid", 64'(bus.resp_valid),  64'(e_rv));
        chk("resp_data",  64'(bus.resp_data),   64'(e_rd));
    endtask

    // One clock cycle: drive, check, clock, advance the model.
    task automatic tick();
        int g;
        logic [CH-1:0] er;
        logic gw; logic [AW-1:0] ga; logic [DW-1:0] gd;
        resp_t r;
        apply();
        #1;
        g = pick(bus.req_valid, bus.mem_ready);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk_outputs();
        gw = 1'b0; ga = '0; gd = '0;
        if (g >= 0) begin gw = p_wen[g]; ga = p_addr[g]; gd = p_data[g]; end
        @(posedge clk);
        cyc++;
        e_en = (g >= 0);
        if (g >= 0) begin
            e_wen = gw; e_addr = ga; e_wdata = gd;
            ptr = (g + 1) % CH;
            p_valid[g] = 1'b0;
            if (gw) ref_mem[int'(ga)] = gd;
            else pend.push_back('{cyc + 1 + LAT, g,
                                  ref_mem.exists(int'(ga)) ? ref_mem[int'(ga)] : ga + 16'd1});
        end
        e_rv = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            e_rv[r.ch] = 1'b1;
            e_rd[r.ch*DW +: DW] = r.d;
        end
        @(negedge clk);
    endtask

    initial begin
        cyc = 0;
        for (int k = 0; k < CH; k++) begin
            p_valid[k] = 1'b0; p_wen[k] = 1'b0; p_addr[k] = '0; p_data[k] = '0;
        end
        apply();
        bus.mem_ready = 1'b1;
        model_reset();
        reset_n = 1'b1;

        // Reset asserted mid-cycle: outputs clear without a clock edge
        #3 reset_n = 1'b0;
        #1 chk_outputs();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        repeat (3) tick();

        // Single channel-1 read
        set_req(1, 1'b0, 16'h0010, 16'h0000);
        repeat (6) tick();

        // All channels contending for six cycles, reads only
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < CH; k++)
                if (!p_valid[k]) set_req(k, 1'b0, AW'(16'h0020 + 16'(c*CH + k)), 16'h0000);
            tick();
        end
        for (int k = 0; k < CH; k++) p_valid[k] = 1'b0;
        repeat (5) tick();

        // Write then read the same address from another channel
        set_req(0, 1'b1, 16'h0400, 16'hBEEF);
        tick();
        set_req(2, 1'b0, 16'h0400, 16'h0000);
        repeat (6) tick();

        // DRAM back-pressure with all channels valid, then resume
        for (int k = 0; k < CH; k++) set_req(k, 1'b0, AW'(16'h0030 + 16'(k)), 16'h0000);
        tick();
        bus.mem_ready = 1'b0;
        for (int k = 0; k < CH; k++)
            if (!p_valid[k]) set_req(k, 1'b0, AW'(16'h0040 + 16'(k)), 16'h0000);
        repeat (3) tick();
        bus.mem_ready = 1'b1;
        repeat (3) tick();
        repeat (5) tick();

        // Reset with two reads in flight: their returns must never appear
        set_req(0, 1'b0, 16'h0050, 16'h0000);
        set_req(1, 1'b0, 16'h0051, 16'h0000);
        tick(); tick();
        reset_n = 1'b0;
        model_reset();
        #1 chk_outputs();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) tick();

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < CH; k++)
                if (!p_valid[k] && ($urandom_range(0, 1) == 1))
                    set_req(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        for (int k = 0; k < CH; k++) p_valid[k] = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
